// File: rtl/brownout_ctrl.sv
// brownout_ctrl
//   Always-on supervisor for the brownout analog macro. Drives the macro's
//   enable and trip codes and turns its asynchronous comparator outputs
//   into a debounced, held system reset plus sticky status and an event
//   counter. Clocked from the macro oscillator (osc_ck).
//
//   Optional feature macro: BROWNOUT_CTRL_VUNDER_EN
//     defined   : vunder is synchronized and drives vunder_warn/vunder_flag
//     undefined : vunder is ignored, vunder_warn/vunder_flag tie to 0
//
// Ports
//   osc_ck      in   clock
//   rst_n       in   async active-low reset
//   cfg_ena     in   monitor enable request
//   cfg_otrip   in   [2:0] brownout trip code request
//   cfg_vtrip   in   [2:0] undervoltage trip code request
//   clr_stat    in   pulse, clears sticky flags
//   brout       in   async comparator, 1 = avdd below otrip
//   vunder      in   async comparator, 1 = avdd below vtrip
//   ena         out  macro enable
//   otrip       out  [2:0] macro brownout trip code
//   vtrip       out  [2:0] macro undervoltage trip code
//   sys_rst_n   out  active-low system reset
//   brout_flag  out  sticky brownout flag
//   vunder_warn out  qualified undervoltage warning (level)
//   vunder_flag out  sticky undervoltage flag
//   evt_cnt     out  [CNT_W-1:0] saturating brownout event count
module brownout_ctrl #(
  parameter int DEB_CYC    = 4,
  parameter int SETTLE_CYC = 16,
  parameter int HOLD_CYC   = 64,
  parameter int CNT_W      = 8
) (
  input  logic             osc_ck,
  input  logic             rst_n,
  input  logic             cfg_ena,
  input  logic [2:0]       cfg_otrip,
  input  logic [2:0]       cfg_vtrip,
  input  logic             clr_stat,
  input  logic             brout,
  input  logic             vunder,
  output logic             ena,
  output logic [2:0]       otrip,
  output logic [2:0]       vtrip,
  output logic             sys_rst_n,
  output logic             brout_flag,
  output logic             vunder_warn,
  output logic             vunder_flag,
  output logic [CNT_W-1:0] evt_cnt
);

  // Counters only need to reach N-1: the terminal cycle is detected on the
  // compare and the counter is cleared on the resulting state change.
  localparam int DEB_W = (DEB_CYC    > 1) ? $clog2(DEB_CYC)    : 1;
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int HLD_W = (HOLD_CYC   > 1) ? $clog2(HOLD_CYC)   : 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_ARM  = 3'd1,
    S_MON  = 3'd2,
    S_TRIP = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t           r_state;
  logic [DEB_W-1:0] r_deb;
  logic [SET_W-1:0] r_settle;
  logic [HLD_W-1:0] r_hold;
  logic             r_ena;
  logic [2:0]       r_otrip;
  logic [2:0]       r_vtrip;
  logic             r_sys_rst_n;
  logic             r_brout_flag;
  logic [CNT_W-1:0] r_evt_cnt;

  // brout synchronizer
  logic r_brout_s1, r_brout_s2;
  logic w_brout;

  always_ff @(posedge osc_ck or negedge rst_n) begin
    if (!rst_n) begin
      r_brout_s1 <= 1'b0;
      r_brout_s2 <= 1'b0;
    end else begin
      r_brout_s1 <= brout;
      r_brout_s2 <= r_brout_s1;
    end
  end

  assign w_brout = r_brout_s2;

  // A code request differing from what the macro currently sees means the
  // comparator is about to move its threshold and must be re-settled.
  logic w_code_chg;
  assign w_code_chg = (cfg_otrip != r_otrip) || (cfg_vtrip != r_vtrip);

  always_ff @(posedge osc_ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_OFF;
      r_deb        <= '0;
      r_settle     <= '0;
      r_hold       <= '0;
      r_ena        <= 1'b0;
      r_otrip      <= 3'd0;
      r_vtrip      <= 3'd0;
      r_sys_rst_n  <= 1'b1;
      r_brout_flag <= 1'b0;
      r_evt_cnt    <= '0;
    end else begin
      r_otrip <= cfg_otrip;
      r_vtrip <= cfg_vtrip;

      // Clear first; a set later in this block overrides it (set wins).
      if (clr_stat) r_brout_flag <= 1'b0;

      if (!cfg_ena) begin
        // Disable has priority over every state, including TRIP/HOLD.
        r_state     <= S_OFF;
        r_ena       <= 1'b0;
        r_sys_rst_n <= 1'b1;
        r_deb       <= '0;
        r_settle    <= '0;
        r_hold      <= '0;
      end else begin
        case (r_state)
          S_OFF: begin
            r_state  <= S_ARM;
            r_ena    <= 1'b1;
            r_settle <= '0;
          end

          S_ARM: begin
            if (w_code_chg) begin
              r_settle <= '0;
            end else if (r_settle == SET_LAST) begin
              r_state  <= S_MON;
              r_settle <= '0;
              r_deb    <= '0;
            end else begin
              r_settle <= r_settle + 1'b1;
            end
          end

          S_MON: begin
            if (w_code_chg) begin
              r_state  <= S_ARM;
              r_settle <= '0;
              r_deb    <= '0;
            end else if (w_brout) begin
              if (r_deb == DEB_LAST) begin
                r_state      <= S_TRIP;
                r_deb        <= '0;
                r_sys_rst_n  <= 1'b0;
                r_brout_flag <= 1'b1;
                if (r_evt_cnt != {CNT_W{1'b1}}) r_evt_cnt <= r_evt_cnt + 1'b1;
              end else begin
                r_deb <= r_deb + 1'b1;
              end
            end else begin
              r_deb <= '0;
            end
          end

          // In TRIP the debounce counter tracks consecutive clean cycles.
          S_TRIP: begin
            if (!w_brout) begin
              if (r_deb == DEB_LAST) begin
                r_state <= S_HOLD;
                r_deb   <= '0;
                r_hold  <= '0;
              end else begin
                r_deb <= r_deb + 1'b1;
              end
            end else begin
              r_deb <= '0;
            end
          end

          // A re-trip during hold is the same brownout, so no new event.
          S_HOLD: begin
            if (w_brout) begin
              r_state <= S_TRIP;
              r_hold  <= '0;
              r_deb   <= '0;
            end else if (r_hold == HLD_LAST) begin
              r_state     <= S_MON;
              r_hold      <= '0;
              r_deb       <= '0;
              r_sys_rst_n <= 1'b1;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end

          default: begin
            r_state     <= S_OFF;
            r_ena       <= 1'b0;
            r_sys_rst_n <= 1'b1;
            r_deb       <= '0;
            r_settle    <= '0;
            r_hold      <= '0;
          end
        endcase
      end
    end
  end

`ifdef BROWNOUT_CTRL_VUNDER_EN
  logic r_vunder_s1, r_vunder_s2;
  logic r_vunder_flag;
  logic w_vu_qual;
  logic w_vunder_warn;

  always_ff @(posedge osc_ck or negedge rst_n) begin
    if (!rst_n) begin
      r_vunder_s1 <= 1'b0;
      r_vunder_s2 <= 1'b0;
    end else begin
      r_vunder_s1 <= vunder;
      r_vunder_s2 <= r_vunder_s1;
    end
  end

  // Warning is meaningless until the comparator has settled, so it is
  // gated to the states that follow ARM. Both terms are flop outputs.
  assign w_vu_qual     = (r_state == S_MON) || (r_state == S_TRIP) ||
                         (r_state == S_HOLD);
  assign w_vunder_warn = r_vunder_s2 & w_vu_qual;

  always_ff @(posedge osc_ck or negedge rst_n) begin
    if (!rst_n)              r_vunder_flag <= 1'b0;
    else if (w_vunder_warn)  r_vunder_flag <= 1'b1;
    else if (clr_stat)       r_vunder_flag <= 1'b0;
  end

  assign vunder_warn = w_vunder_warn;
  assign vunder_flag = r_vunder_flag;
`else
  logic w_vunder_unused;
  assign w_vunder_unused = vunder;
  assign vunder_warn     = 1'b0;
  assign vunder_flag     = 1'b0;
`endif

  assign ena        = r_ena;
  assign otrip      = r_otrip;
  assign vtrip      = r_vtrip;
  assign sys_rst_n  = r_sys_rst_n;
  assign brout_flag = r_brout_flag;
  assign evt_cnt    = r_evt_cnt;

endmodule

// File: tb/tb_brownout_ctrl.sv
module tb_brownout_ctrl;

  localparam int ENA = 0, RST = 1, EVT = 2, BFLAG = 3;
  localparam int OTRIP = 4, VTRIP = 5, WARN = 6, VFLAG = 7;

`ifdef BROWNOUT_CTRL_VUNDER_EN
  localparam int VU = 1;
`else
  localparam int VU = 0;
`endif

  logic       osc_ck = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_ena = 1'b0;
  logic [2:0] cfg_otrip = 3'd7;
  logic [2:0] cfg_vtrip = 3'd5;
  logic       clr_stat = 1'b0;
  logic       brout = 1'b0;
  logic       vunder = 1'b0;
  logic       ena;
  logic [2:0] otrip;
  logic [2:0] vtrip;
  logic       sys_rst_n;
  logic       brout_flag;
  logic       vunder_warn;
  logic       vunder_flag;
  logic [7:0] evt_cnt;

  brownout_ctrl dut (
    .osc_ck      (osc_ck),
    .rst_n       (rst_n),
    .cfg_ena     (cfg_ena),
    .cfg_otrip   (cfg_otrip),
    .cfg_vtrip   (cfg_vtrip),
    .clr_stat    (clr_stat),
    .brout       (brout),
    .vunder      (vunder),
    .ena         (ena),
    .otrip       (otrip),
    .vtrip       (vtrip),
    .sys_rst_n   (sys_rst_n),
    .brout_flag  (brout_flag),
    .vunder_warn (vunder_warn),
    .vunder_flag (vunder_flag),
    .evt_cnt     (evt_cnt)
  );

  always #5 osc_ck = ~osc_ck;

  typedef struct {
    int         tgt;
    int         sig;
    logic [7:0] val;
  } exp_t;

  exp_t  sb_q[$];
  int    cyc = 0;
  int    n_vec = 0;
  int    n_miss = 0;
  string sig_name [8] = '{"ena", "sys_rst_n", "evt_cnt", "brout_flag",
                          "otrip", "vtrip", "vunder_warn", "vunder_flag"};
  logic [7:0] mon_act;

  initial forever begin
    @(posedge osc_ck);
    cyc++;
  end

  function automatic logic [7:0] actual(int sig);
    case (sig)
      ENA:     return {7'd0, ena};
      RST:     return {7'd0, sys_rst_n};
      EVT:     return evt_cnt;
      BFLAG:   return {7'd0, brout_flag};
      OTRIP:   return {5'd0, otrip};
      VTRIP:   return {5'd0, vtrip};
      WARN:    return {7'd0, vunder_warn};
      default: return {7'd0, vunder_flag};
    endcase
  endfunction

  // Monitor: each cycle, pop every expectation due on this cycle.
  initial forever begin
    @(negedge osc_ck);
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].tgt <= cyc) begin
        mon_act = actual(sb_q[i].sig);
        n_vec++;
        if (mon_act !== sb_q[i].val) begin
          n_miss++;
          $display("FAIL %s @cyc %0d: got %0d expected %0d",
                   sig_name[sb_q[i].sig], cyc, mon_act, sb_q[i].val);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic go(int n);
    repeat (n) @(posedge osc_ck);
    #1;
  endtask

  // Expect signal sig to hold val after the edge 'off' cycles from now.
  task automatic ex(int off, int sig, int val);
    exp_t e;
    e.tgt = cyc + off;
    e.sig = sig;
    e.val = 8'(val);
    sb_q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete, got running expected done");
    n_miss++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    go(3);
    ex(0, ENA, 0); ex(0, OTRIP, 0); ex(0, VTRIP, 0); ex(0, RST, 1);
    ex(0, BFLAG, 0); ex(0, EVT, 0); ex(0, WARN, 0); ex(0, VFLAG, 0);
    n_vec++;
    if (ena !== 1'b0) begin
      n_miss++;
      $display("FAIL ena in reset: got %0d expected 0", ena);
    end
    n_vec++;
    if (sys_rst_n !== 1'b1) begin
      n_miss++;
      $display("FAIL sys_rst_n in reset: got %0d expected 1", sys_rst_n);
    end
    n_vec++;
    if (evt_cnt !== 8'd0) begin
      n_miss++;
      $display("FAIL evt_cnt in reset: got %0d expected 0", evt_cnt);
    end
    go(1);
    rst_n = 1'b1;
    go(2);
    ex(0, OTRIP, 7); ex(0, VTRIP, 5);

    // Enable and settle with brout already high
    cfg_ena = 1'b1; brout = 1'b1;
    ex(0, ENA, 0); ex(1, ENA, 1); ex(17, RST, 1); ex(20, RST, 1);
    ex(21, RST, 0); ex(21, EVT, 1); ex(21, BFLAG, 1);
    go(21);
    n_vec++;
    if (sys_rst_n !== 1'b0) begin
      n_miss++;
      $display("FAIL sys_rst_n at MON cycle 4: got %0d expected 0", sys_rst_n);
    end
    n_vec++;
    if (evt_cnt !== 8'd1) begin
      n_miss++;
      $display("FAIL evt_cnt after first trip: got %0d expected 1", evt_cnt);
    end
    n_vec++;
    if (brout_flag !== 1'b1) begin
      n_miss++;
      $display("FAIL brout_flag after first trip: got %0d expected 1", brout_flag);
    end
    brout = 1'b0;
    ex(69, RST, 0); ex(70, RST, 1);
    go(70);

    // Debounce: 3-cycle glitch is rejected
    brout = 1'b1;
    ex(6, RST, 1); ex(8, RST, 1); ex(8, EVT, 1);
    go(3);
    brout = 1'b0;
    go(8);

    // Status clear
    clr_stat = 1'b1;
    ex(1, BFLAG, 0);
    go(1);
    clr_stat = 1'b0;
    ex(1, BFLAG, 0);
    go(2);

    // Full event: 50 cycles high
    brout = 1'b1;
    ex(5, RST, 1); ex(6, RST, 0); ex(6, EVT, 2); ex(6, BFLAG, 1);
    go(50);
    brout = 1'b0;
    ex(69, RST, 0); ex(70, RST, 1);
    go(70);

    // Re-trip during HOLD
    brout = 1'b1;
    ex(6, RST, 0); ex(6, EVT, 3);
    go(10);
    brout = 1'b0;
    ex(36, RST, 0); ex(38, RST, 0); ex(40, RST, 0);
    go(36);
    brout = 1'b1;
    go(5);
    brout = 1'b0;
    ex(3, RST, 0); ex(69, RST, 0); ex(70, RST, 1); ex(70, EVT, 3);
    go(70);

    // otrip change in MON restarts ARM; clr_stat coincident with trip
    cfg_otrip = 3'd3; brout = 1'b1;
    ex(0, OTRIP, 7); ex(1, OTRIP, 3); ex(1, ENA, 1);
    ex(6, RST, 1); ex(20, RST, 1); ex(21, RST, 0); ex(21, EVT, 4);
    go(20);
    clr_stat = 1'b1;
    go(1);
    clr_stat = 1'b0;
    ex(0, BFLAG, 1);
    // vtrip change in TRIP: applied, state kept
    cfg_vtrip = 3'd2; brout = 1'b0;
    ex(0, VTRIP, 5); ex(1, VTRIP, 2); ex(3, RST, 0);
    ex(69, RST, 0); ex(70, RST, 1);
    go(70);

    // Disable during TRIP
    brout = 1'b1;
    ex(6, RST, 0); ex(6, EVT, 5);
    go(8);
    cfg_ena = 1'b0;
    ex(0, RST, 0); ex(1, RST, 1); ex(1, ENA, 0); ex(1, EVT, 5);
    go(1);
    // vunder in OFF
    vunder = 1'b1;
    ex(4, WARN, 0); ex(4, VFLAG, 0);
    go(4);
    vunder = 1'b0;
    go(3);

    // Saturation: 300 more events via enable cycling
    for (int i = 0; i < 300; i++) begin
      cfg_ena = 1'b1;
      go(22);
      ex(0, RST, 0);
      ex(0, EVT, (5 + i + 1 > 255) ? 255 : 5 + i + 1);
      cfg_ena = 1'b0;
      go(1);
    end

    // vunder in ARM is masked
    brout = 1'b0; cfg_ena = 1'b1; vunder = 1'b1;
    ex(5, WARN, 0); ex(10, VFLAG, 0);
    go(10);
    vunder = 1'b0;
    go(12);
    // vunder in MON
    vunder = 1'b1;
    ex(1, WARN, 0); ex(2, WARN, VU); ex(3, VFLAG, VU);
    go(3);
    vunder = 1'b0;
    ex(3, WARN, 0); ex(6, VFLAG, VU);
    go(6);
    clr_stat = 1'b1;
    ex(1, VFLAG, 0);
    go(1);
    clr_stat = 1'b0;
    go(2);

    // Asynchronous reset mid-operation, checked before the next edge
    ex(0, ENA, 1); ex(0, EVT, 255);
    go(1);
    rst_n = 1'b0;
    ex(0, EVT, 0); ex(0, ENA, 0); ex(0, RST, 1); ex(0, BFLAG, 0);
    ex(0, OTRIP, 0); ex(0, VTRIP, 0);
    #1;
    n_vec++;
    if (evt_cnt !== 8'd0) begin
      n_miss++;
      $display("FAIL evt_cnt on async reset: got %0d expected 0", evt_cnt);
    end
    n_vec++;
    if (ena !== 1'b0) begin
      n_miss++;
      $display("FAIL ena on async reset: got %0d expected 0", ena);
    end
    n_vec++;
    if (sys_rst_n !== 1'b1) begin
      n_miss++;
      $display("FAIL sys_rst_n on async reset: got %0d expected 1", sys_rst_n);
    end
    go(2);
    rst_n = 1'b1;
    go(3);

    while (sb_q.size() > 0) begin
      n_miss++;
      $display("FAIL %s: got unchecked expected check at cyc %0d",
               sig_name[sb_q[0].sig], sb_q[0].tgt);
      sb_q.delete(0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/brownout_ctrl.md
# brownout_ctrl

Digital supervisor on the consumer side of the `brownout` analog macro. It drives the macro's trip-select and enable inputs and receives its asynchronous comparator outputs. The received outputs are synchronized, debounced and sequenced into a held system reset, with sticky status and a brownout event counter. It sits in the always-on digital domain, clocked from the macro's `osc_ck`.

## Interface
Parameters:
- `DEB_CYC`, 4: consecutive synchronized cycles needed to accept a level change on `brout`; legal range ≥1.
- `SETTLE_CYC`, 16: cycles the comparator is ignored after enable or a trip-code change; legal range ≥1.
- `HOLD_CYC`, 64: cycles `sys_rst_n` stays low after `brout` is cleanly deasserted; legal range ≥1.
- `CNT_W`, 8: width of `evt_cnt`.

Ports:
- `osc_ck`, input, 1: clock.
- `rst_n`, input, 1: asynchronous active-low reset. The clock is `osc_ck`.
- `cfg_ena`, input, 1: monitor enable request.
- `cfg_otrip`, input, 3: brownout trip code request.
- `cfg_vtrip`, input, 3: undervoltage trip code request.
- `clr_stat`, input, 1: one-cycle pulse that clears the sticky flags.
- `brout`, input, 1: async from macro `out`; 1 = avdd below otrip.
- `vunder`, input, 1: async from macro `vunder`; 1 = avdd below vtrip.
- `ena`, output, 1: to macro `ena`.
- `otrip`, output, 3: to macro `otrip`.
- `vtrip`, output, 3: to macro `vtrip`.
- `sys_rst_n`, output, 1: active-low system reset.
- `brout_flag`, output, 1: sticky; set when any brownout is accepted.
- `vunder_warn`, output, 1: level; qualified undervoltage warning.
- `vunder_flag`, output, 1: sticky undervoltage flag.
- `evt_cnt`, output, CNT_W: saturating count of brownout events.

## Operation
- `brout` and `vunder` each pass through a 2-flop synchronizer before any use.
- FSM states: OFF, ARM, MON, TRIP, HOLD. The reset state is OFF.
- OFF: `ena`=0. Entered from any state one cycle after `cfg_ena`=0. On entry, the debounce, settle and hold counters are cleared. `evt_cnt` and the flags are kept.
- OFF→ARM when `cfg_ena`=1.
- ARM: `ena`=1. The synchronized comparators are ignored. After SETTLE_CYC cycles in ARM, go to MON.
- MON: the debounce counter counts consecutive cycles with synchronized `brout`=1. Any 0 resets the counter. When the count reaches DEB_CYC, go to TRIP. On that transition, `evt_cnt` increments and saturates at all-ones, and `brout_flag` is set.
- TRIP: `sys_rst_n`=0. The debounce counter counts consecutive cycles with synchronized `brout`=0. When the count reaches DEB_CYC, go to HOLD.
- HOLD: `sys_rst_n`=0. Counts HOLD_CYC cycles, then goes to MON. If synchronized `brout`=1 in any HOLD cycle, return to TRIP at once, clear the hold counter, and do not count a new event.
- Trip codes: `otrip` and `vtrip` register `cfg_otrip` and `cfg_vtrip` every cycle.
  - In ARM or MON, a change in either code forces ARM and restarts the settle count.
  - In TRIP or HOLD, a code change is applied to the outputs but the state is unchanged.
- `clr_stat` clears `brout_flag` and `vunder_flag`. If a set and a clear happen in the same cycle, the set wins. `clr_stat` does not clear `evt_cnt`.

## Timing
- Values while `rst_n`=0:
  - `ena`=0, `otrip`=0, `vtrip`=0.
  - `sys_rst_n`=1.
  - `brout_flag`=0, `vunder_flag`=0, `vunder_warn`=0.
  - `evt_cnt`=0.
  - Synchronizer flops: 0.
- All outputs are registered.
- `cfg_ena` rising to `ena`=1: 1 cycle.
- `brout` rising to `sys_rst_n` low: 2 + DEB_CYC cycles (`brout` held steadily high, in MON).
- `brout` falling to `sys_rst_n` high: 2 + DEB_CYC + HOLD_CYC cycles (no re-trip).
- `cfg_ena`=0 during TRIP or HOLD: state becomes OFF and `sys_rst_n`=1 on the next edge.
- `rst_n` asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.

## Configuration
- `BROWNOUT_CTRL_VUNDER_EN` defined:
  - `vunder_warn` = synchronized `vunder`, qualified so it can be 1 only in MON, TRIP or HOLD.
  - `vunder_flag` is set on any cycle where `vunder_warn`=1.
- `BROWNOUT_CTRL_VUNDER_EN` undefined:
  - The `vunder` input is unused and there is no synchronizer for it.
  - `vunder_warn`=0 and `vunder_flag`=0 constantly.
  - `vtrip` still follows `cfg_vtrip`.

## Test plan
All scenarios use default parameters.
- Enable and settle: reset, then `cfg_ena`=1 and `brout`=1 throughout. Required: `ena`=1 after 1 cycle; no trip for 16 cycles of ARM; `sys_rst_n`=0 on MON cycle 4.
- Debounce: pulse `brout` high for 3 cycles in MON. Required: `sys_rst_n` stays 1 and `evt_cnt`=0.
- Full event: hold `brout` high for 50 cycles, then low. Required: `sys_rst_n` low 6 cycles after the rise, high 70 cycles after the fall; `evt_cnt`=1; `brout_flag`=1.
- Re-trip in HOLD: set `brout`=1 at HOLD cycle 30. Required: return to TRIP; `sys_rst_n` stays 0 throughout; `evt_cnt` unchanged; full 64-cycle hold after the next clean release.
- Config and status:
  - Change `cfg_otrip` from 7 to 3 in MON. Required: `otrip`=3 one cycle later; ARM restarts.
  - Assert `clr_stat` on the same cycle as a MON→TRIP transition. Required: `brout_flag` stays 1.
  - Produce 300 events. Required: `evt_cnt`=255.
- Vunder, with the macro defined:
  - `vunder`=1 in MON. Required: `vunder_warn` high after 2 cycles; `vunder_flag` set and holds after `vunder`=0 until `clr_stat`.
  - `vunder`=1 in OFF or ARM. Required: `vunder_warn`=0.
